sub_share_ctrl: RTL and testbench

//  Scheduler that shares one Sub32Bit subtractor between two requesters.
//  - Arbitrates the two requesters round-robin.
//  - Latches the winner's operands and holds them stable while the ripple subtractor settles.
//  - Waits a programmed number of settle cycles, then captures the difference and status flags.
//  - Returns the result with a one-cycle done pulse tagged with the requester id.

---
 rtl/sub_share_pkg.sv | 23 ++
 rtl/Sub32Bit.sv | 13 +
 rtl/sub_share_ctrl.sv | 111 +++++++++++
 tb/tb_sub_share_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sub_share_pkg.sv
// Shared definitions for the Sub32Bit sharing controller: datapath width,
// default settle time, FSM encoding and the round-robin pick rule.
package sub_share_pkg;

    localparam int DATA_W            = 32;
    localparam int SETTLE_CYCLES_DEF = 4;

    // Encoding 2'd3 is unused and falls back to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // A lone requester wins; with both asking, the one not served last wins.
    function automatic logic rr_pick(input logic [1:0] req, input logic last);
        if (req == 2'b11) begin
            return ~last;
        end
        return req[1];
    endfunction

endpackage

// File: rtl/Sub32Bit.sv
// Combinational 32-bit subtractor (diff = op_a - op_b, modulo 2^32) with no
// carry-out; it needs several clocks to settle when it lands on a ripple chain.
module Sub32Bit
    import sub_share_pkg::*;
(
    output logic [DATA_W-1:0] diff,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b
);

    assign diff = op_a - op_b;

endmodule

// File: rtl/sub_share_ctrl.sv
// Round-robin scheduler sharing one Sub32Bit between two requesters: latches the
// winner's operands, waits SETTLE_CYCLES edges, then captures difference and flags.
module sub_share_ctrl
    import sub_share_pkg::*;
#(
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter int CNT_W         = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [DATA_W-1:0] a0,
    input  logic [DATA_W-1:0] b0,
    input  logic [DATA_W-1:0] a1,
    input  logic [DATA_W-1:0] b1,
    output logic [1:0]        gnt,
    output logic              busy,
    output logic              done,
    output logic              done_id,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              neg,
    output logic              borrow,
    output logic              ovf,
    output state_t            dbg_state
);

    // Handshake: a requester raises req[i] with stable operands and holds it until
    // its done pulse; gnt is one-hot from the grant edge through the done cycle, and
    // a req still high when the FSM is back in IDLE counts as a fresh request.

    state_t            state;
    logic              rr_last;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] diff;
    logic              win;

    assign win       = rr_pick(req, rr_last);
    assign dbg_state = state;

    // The subtractor only ever sees the latched operands.
    Sub32Bit u_sub (
        .diff (diff),
        .op_a (op_a),
        .op_b (op_b)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            gnt     <= 2'b00;
            busy    <= 1'b0;
            done    <= 1'b0;
            done_id <= 1'b0;
            result  <= '0;
            zero    <= 1'b0;
            neg     <= 1'b0;
            borrow  <= 1'b0;
            ovf     <= 1'b0;
            rr_last <= 1'b1;
            op_a    <= '0;
            op_b    <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req != 2'b00) begin
                        state   <= ST_SETTLE;
                        busy    <= 1'b1;
                        gnt     <= win ? 2'b10 : 2'b01;
                        rr_last <= win;
                        op_a    <= win ? a1 : a0;
                        op_b    <= win ? b1 : b0;
                        cnt     <= CNT_W'(SETTLE_CYCLES - 1);
                    end
                end
                ST_SETTLE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        state   <= ST_DONE;
                        done    <= 1'b1;
                        done_id <= rr_last;
                        result  <= diff;
                        zero    <= (diff == '0);
                        neg     <= diff[DATA_W-1];
                        // Unsigned a < b is exactly the borrow out of a - b.
                        borrow  <= (op_a < op_b);
                        ovf     <= (op_a[DATA_W-1] != op_b[DATA_W-1]) &&
                                   (diff[DATA_W-1] != op_a[DATA_W-1]);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    gnt   <= 2'b00;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    gnt   <= 2'b00;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub_share_ctrl.sv
// Self-checking bench for sub_share_ctrl: directed scenarios plus randomized
// operations compared against an arithmetic reference model.
module tb_sub_share_ctrl;
    import sub_share_pkg::*;

    localparam int SC = 4;
    localparam int W  = 37;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req, req_s1;
    logic [31:0] a0, b0, a1, b1;

    logic [1:0]  gnt, s1_gnt;
    logic        busy, done, done_id, zero, neg, borrow, ovf;
    logic        s1_busy, s1_done, s1_done_id, s1_zero, s1_neg, s1_borrow, s1_ovf;
    logic [31:0] result, s1_result;
    state_t      dbg_state, s1_dbg_state;

    logic [W-1:0] obs, s1_obs;
    assign obs    = {done_id, zero, neg, borrow, ovf, result};
    assign s1_obs = {s1_done_id, s1_zero, s1_neg, s1_borrow, s1_ovf, s1_result};

    int           n_cmp  = 0;
    int           n_fail = 0;
    logic         rr_model;
    logic [W-1:0] exp_q[$];

    sub_share_ctrl #(.SETTLE_CYCLES(SC), .CNT_W(8)) u_dut (
        .clk(clk), .reset(reset), .req(req),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt(gnt), .busy(busy), .done(done), .done_id(done_id),
        .result(result), .zero(zero), .neg(neg), .borrow(borrow), .ovf(ovf),
        .dbg_state(dbg_state)
    );

    sub_share_ctrl #(.SETTLE_CYCLES(1), .CNT_W(8)) u_dut_s1 (
        .clk(clk), .reset(reset), .req(req_s1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt(s1_gnt), .busy(s1_busy), .done(s1_done), .done_id(s1_done_id),
        .result(s1_result), .zero(s1_zero), .neg(s1_neg), .borrow(s1_borrow), .ovf(s1_ovf),
        .dbg_state(s1_dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic apply_reset();
        reset = 1'b1;
        req   = 2'b00;
        req_s1 = 2'b00;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        rr_model = 1'b1;
    endtask

    // ---------------- reference model ----------------
    function automatic logic model_pick(input logic [1:0] r, input logic last);
        if (r == 2'b11) return ~last;
        return (r == 2'b10);
    endfunction

    function automatic logic [W-1:0] model(input logic id, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] d;
        longint      sd;
        logic        bo, ov;
        d  = a - b;
        bo = (a < b);
        sd = longint'($signed(a)) - longint'($signed(b));
        ov = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
        return {id, (d == 32'd0), d[31], bo, ov, d};
    endfunction

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic wait_idle(output bit to);
        int k = 0;
        while (busy !== 1'b0 && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        to = (busy !== 1'b0);
    endtask

    task automatic wait_done(output int lat, output bit to);
        bit seen = 1'b0;
        lat = 0;
        while (!seen && lat < SC + 10) begin
            @(posedge clk); #1;
            lat++;
            seen = (done === 1'b1);
        end
        to = !seen;
    endtask

    task automatic issue(input logic [1:0] r, output int lat, output logic [1:0] g, output bit to);
        bit to1, to2;
        wait_idle(to1);
        req = r;
        @(posedge clk); #1;
        g = gnt;
        wait_done(lat, to2);
        to = to1 | to2;
        req = 2'b00;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; req = 2'b00; req_s1 = 2'b00;
        a0 = 0; b0 = 0; a1 = 0; b1 = 0;
        #2;
        n_cmp++; if (obs !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", obs); end
        n_cmp++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b want 00", gnt); end
        n_cmp++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL reset_busy_done: got %b want 00", {busy, done}); end
        n_cmp++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
        @(posedge clk); #1 reset = 1'b0;
        rr_model = 1'b1;
    endtask

    task automatic test_single();
        int lat; logic [1:0] g; bit to; logic [W-1:0] exp;
        a0 = 32'd8; b0 = 32'd9; a1 = $urandom; b1 = $urandom;
        exp = model(model_pick(2'b01, rr_model), 32'd8, 32'd9);
        rr_model = 1'b0;
        issue(2'b01, lat, g, to);
        n_cmp++; if (to) begin n_fail++; $display("FAIL single_timeout: got timeout want done"); end
        n_cmp++; if (g !== 2'b01) begin n_fail++; $display("FAIL single_gnt: got %b want 01", g); end
        n_cmp++; if (lat != SC) begin n_fail++; $display("FAIL single_latency: got %0d want %0d", lat, SC); end
        n_cmp++; if (obs !== exp) begin n_fail++; $display("FAIL single_result: got %h want %h", obs, exp); end
        n_cmp++; if (dbg_state !== ST_DONE) begin n_fail++; $display("FAIL single_state: got %0d want 2", dbg_state); end
        @(posedge clk); #1;
        n_cmp++; if ({done, busy, gnt} !== 4'b0000) begin n_fail++; $display("FAIL single_release: got %b want 0000", {done, busy, gnt}); end
    endtask

    task automatic test_round_robin();
        int ops = 0; int cyc = 0; logic [W-1:0] e; logic w;
        apply_reset();
        a0 = 32'd11; b0 = 32'd1; a1 = 32'd11; b1 = 32'd15;
        w = model_pick(2'b11, rr_model);
        exp_q.push_back(model(w, w ? a1 : a0, w ? b1 : b0));
        exp_q.push_back(model(~w, w ? a0 : a1, w ? b0 : b1));
        req = 2'b11;
        while (ops < 2 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            n_cmp++; if ($countones(gnt) > 1) begin n_fail++; $display("FAIL rr_onehot: got %b want at most one bit", gnt); end
            if (done === 1'b1) begin
                e = exp_q.pop_front();
                n_cmp++; if (obs !== e) begin n_fail++; $display("FAIL rr_result: got %h want %h", obs, e); end
                req[e[W-1]] = 1'b0;
                rr_model = e[W-1];
                ops++;
            end
        end
        req = 2'b00;
        exp_q.delete();
        n_cmp++; if (ops != 2) begin n_fail++; $display("FAIL rr_count: got %0d want 2", ops); end
    endtask

    task automatic test_late_operand();
        int lat; bit to; logic [W-1:0] exp;
        wait_idle(to);
        a0 = 32'd27; b0 = 32'd3;
        exp = model(model_pick(2'b01, rr_model), 32'd27, 32'd3);
        rr_model = 1'b0;
        req = 2'b01;
        @(posedge clk); #1;
        @(posedge clk); #1;
        a0 = 32'd0; b0 = 32'h0000_FFFF;
        wait_done(lat, to);
        req = 2'b00;
        n_cmp++; if (to || (lat + 1 != SC)) begin n_fail++; $display("FAIL late_latency: got %0d want %0d", lat + 1, SC); end
        n_cmp++; if (obs !== exp) begin n_fail++; $display("FAIL late_result: got %h want %h", obs, exp); end
    endtask

    task automatic test_boundaries();
        logic        ids[3]  = '{1'b1, 1'b0, 1'b0};
        logic [31:0] av[3]   = '{32'd11, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bv[3]   = '{32'd1025, 32'h8000_0000, 32'd1};
        int lat; logic [1:0] g; bit to; logic [W-1:0] exp;
        for (int i = 0; i < 3; i++) begin
            a0 = ids[i] ? $urandom : av[i]; b0 = ids[i] ? $urandom : bv[i];
            a1 = ids[i] ? av[i] : $urandom; b1 = ids[i] ? bv[i] : $urandom;
            exp = model(ids[i], av[i], bv[i]);
            rr_model = ids[i];
            issue(ids[i] ? 2'b10 : 2'b01, lat, g, to);
            n_cmp++; if (to || obs !== exp) begin n_fail++; $display("FAIL boundary_%0d: got %h want %h", i, obs, exp); end
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic [1:0] g; bit to; logic [W-1:0] exp;
        wait_idle(to);
        a0 = $urandom; b0 = $urandom;
        req = 2'b01;
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        n_cmp++; if (obs !== '0) begin n_fail++; $display("FAIL midreset_outputs: got %h want 0", obs); end
        n_cmp++; if ({gnt, busy, done} !== 4'b0000) begin n_fail++; $display("FAIL midreset_ctrl: got %b want 0000", {gnt, busy, done}); end
        n_cmp++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL midreset_state: got %0d want 0", dbg_state); end
        req = 2'b00;
        for (int i = 0; i < SC + 2; i++) begin
            @(posedge clk); #1;
            n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL midreset_nodone: got %b want 0", done); end
        end
        reset = 1'b0;
        rr_model = 1'b1;
        a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
        exp = model(model_pick(2'b11, rr_model), a0, b0);
        rr_model = 1'b0;
        issue(2'b11, lat, g, to);
        n_cmp++; if (to || g !== 2'b01 || lat != SC) begin n_fail++; $display("FAIL midreset_regrant: got gnt=%b lat=%0d want 01/%0d", g, lat, SC); end
        n_cmp++; if (obs !== exp) begin n_fail++; $display("FAIL midreset_result: got %h want %h", obs, exp); end
    endtask

    task automatic test_back_to_back();
        int ops = 0; int cyc = 0; int last = 0; logic w; logic [W-1:0] exp; bit to;
        wait_idle(to);
        a0 = pick_val(); b0 = pick_val(); a1 = pick_val(); b1 = pick_val();
        req = 2'b11;
        while (ops < 6 && cyc < 6 * (SC + 2) + 20) begin
            @(posedge clk); #1;
            cyc++;
            if (done === 1'b1) begin
                w = model_pick(2'b11, rr_model);
                exp = model(w, w ? a1 : a0, w ? b1 : b0);
                n_cmp++; if (obs !== exp) begin n_fail++; $display("FAIL b2b_op%0d: got %h want %h", ops, obs, exp); end
                if (ops > 0) begin
                    n_cmp++; if (cyc - last != SC + 2) begin n_fail++; $display("FAIL b2b_spacing: got %0d want %0d", cyc - last, SC + 2); end
                end
                last = cyc;
                rr_model = w;
                ops++;
            end
        end
        req = 2'b00;
        n_cmp++; if (ops != 6) begin n_fail++; $display("FAIL b2b_count: got %0d want 6", ops); end
    endtask

    task automatic test_random();
        int lat; logic [1:0] g; bit to; logic id; logic [W-1:0] e;
        for (int i = 0; i < 20; i++) begin
            id = 1'($urandom_range(0, 1));
            a0 = pick_val(); b0 = pick_val(); a1 = pick_val(); b1 = pick_val();
            exp_q.push_back(model(id, id ? a1 : a0, id ? b1 : b0));
            rr_model = id;
            issue(id ? 2'b10 : 2'b01, lat, g, to);
            e = exp_q.pop_front();
            n_cmp++; if (to || lat != SC) begin n_fail++; $display("FAIL rand_latency_%0d: got %0d want %0d", i, lat, SC); end
            n_cmp++; if (obs !== e) begin n_fail++; $display("FAIL rand_result_%0d: got %h want %h", i, obs, e); end
        end
    endtask

    task automatic test_settle_one();
        logic [W-1:0] exp;
        a0 = pick_val(); b0 = pick_val();
        exp = model(1'b0, a0, b0);
        req_s1 = 2'b01;
        @(posedge clk); #1;
        n_cmp++; if ({s1_busy, s1_done, s1_gnt} !== 4'b1001) begin n_fail++; $display("FAIL s1_grant: got %b want 1001", {s1_busy, s1_done, s1_gnt}); end
        @(posedge clk); #1;
        req_s1 = 2'b00;
        n_cmp++; if (s1_done !== 1'b1) begin n_fail++; $display("FAIL s1_done: got %b want 1", s1_done); end
        n_cmp++; if (s1_obs !== exp) begin n_fail++; $display("FAIL s1_result: got %h want %h", s1_obs, exp); end
        @(posedge clk); #1;
        n_cmp++; if ({s1_done, s1_busy} !== 2'b00) begin n_fail++; $display("FAIL s1_release: got %b want 00", {s1_done, s1_busy}); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_late_operand();
        test_boundaries();
        test_reset_mid();
        test_back_to_back();
        test_random();
        test_settle_one();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
